// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter slice.
//   OP_W        operand width fed to the shared multiplier
//   RES_W       product width returned by the multiplier
//   NREQ_DEF    default number of requesters
//   MUL_LAT_DEF default multiplier latency (operands valid -> product valid)
//   idw_f()     width of a requester index for a given requester count
package mult_pkg;

    localparam int OP_W        = 8;
    localparam int RES_W       = 16;
    localparam int NREQ_DEF    = 4;
    localparam int MUL_LAT_DEF = 3;

    function automatic int idw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector.
//   elig_i  eligible mask, one bit per requester
//   last_i  index granted most recently; search begins just after it
//   gnt_o   one-hot grant (all zero when nothing is eligible)
//   idx_o   encoded index of the granted requester (0 when none)
//   any_o   high when some requester was granted
module rr_picker
    import mult_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = idw_f(NREQ)
) (
    input  logic [NREQ-1:0] elig_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int             cand;
    logic [IDW-1:0] cidx;

    // Walk last+1 .. last+NREQ (mod NREQ); the first eligible slot wins.
    // Offset NREQ wraps back onto last itself, so it has lowest priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_i) + k) % NREQ;
            cidx = IDW'(cand);
            if (!any_o && elig_i[cidx]) begin
                any_o       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin front end for one shared pipelined multiplier.
//   clk, reset_n  clock, asynchronous active-low reset
//   hold          blocks new grants; in-flight operations still finish
//   req_valid/req_ready/req_a/req_b  per-requester operand handshake,
//                 requester i on byte lane i of req_a/req_b
//   mul_a, mul_b  registered operands to the external multiplier
//   mul_out       product, valid MUL_LAT cycles after mul_a/mul_b
//   res_valid/res_id/res_out  registered one-cycle tagged result strobe
//   busy          some operation is in flight or being returned
module mult_arbiter
    import mult_pkg::*;
#(
    parameter  int NREQ    = NREQ_DEF,
    parameter  int MUL_LAT = MUL_LAT_DEF,
    localparam int IDW     = idw_f(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [OP_W*NREQ-1:0] req_a,
    input  logic [OP_W*NREQ-1:0] req_b,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic [RES_W-1:0]     mul_out,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [RES_W-1:0]     res_out,
    output logic                 busy
);

    logic [NREQ-1:0][OP_W-1:0] a_vec, b_vec;
    logic [NREQ-1:0]           elig;
    logic [NREQ-1:0]           gnt;
    logic [IDW-1:0]            gidx;
    logic                      xfer;

    logic [NREQ-1:0]           outst_q, outst_d;
    logic [IDW-1:0]            last_q;
    logic [OP_W-1:0]           mul_a_q, mul_b_q;
    // Tag pipeline: stage MUL_LAT lines up with mul_out for the same op.
    logic [MUL_LAT:0]          vld_pipe_q;
    logic [MUL_LAT:0][IDW-1:0] id_pipe_q;
    logic                      res_valid_q;
    logic [IDW-1:0]            res_id_q;
    logic [RES_W-1:0]          res_out_q;

    assign a_vec = req_a;
    assign b_vec = req_b;

    // reset_n gating keeps req_ready low for the whole reset window.
    assign elig = req_valid & ~outst_q & {NREQ{~hold & reset_n}};

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .elig_i (elig),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gidx),
        .any_o  (xfer)
    );

    assign req_ready = gnt;

    // A requester's clear (result return) and its next set can never land
    // on the same edge: it is still outstanding during the return cycle.
    always_comb begin
        outst_d = outst_q;
        if (vld_pipe_q[MUL_LAT]) outst_d[id_pipe_q[MUL_LAT]] = 1'b0;
        if (xfer)                outst_d[gidx]               = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outst_q     <= '0;
            last_q      <= IDW'(NREQ - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            vld_pipe_q  <= '0;
            id_pipe_q   <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_out_q   <= '0;
        end else begin
            outst_q    <= outst_d;
            vld_pipe_q <= {vld_pipe_q[MUL_LAT-1:0], xfer};
            id_pipe_q  <= {id_pipe_q[MUL_LAT-1:0], gidx};
            if (xfer) begin
                mul_a_q <= a_vec[gidx];
                mul_b_q <= b_vec[gidx];
                last_q  <= gidx;
            end
            res_valid_q <= vld_pipe_q[MUL_LAT];
            if (vld_pipe_q[MUL_LAT]) begin
                res_id_q  <= id_pipe_q[MUL_LAT];
                res_out_q <= mul_out;
            end
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_out   = res_out_q;
    // Outstanding bits drop on the edge that raises res_valid; the strobe
    // cycle still counts as busy so the op is covered end to end.
    assign busy      = (|outst_q) | res_valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;
    localparam int NREQ    = 4;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        hold;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_out;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_out;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_out   (res_out),
        .busy      (busy)
    );

    // Behavioural pipelined multiplier, MUL_LAT register stages.
    logic [15:0] mpipe [MUL_LAT];
    always_ff @(posedge clk) begin
        mpipe[0] <= 16'(mul_a) * 16'(mul_b);
        for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_out = mpipe[MUL_LAT-1];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Per-cycle check of grant and result strobe; id/product only on strobe.
    task automatic cyc_chk(input string t, input int c, input logic [3:0] rdy,
                           input bit rv, input int id, input int prod);
        chk($sformatf("%s rdy c%0d", t, c), 32'(req_ready), 32'(rdy));
        chk($sformatf("%s rv c%0d", t, c), 32'(res_valid), 32'(rv));
        if (rv) begin
            chk($sformatf("%s id c%0d", t, c), 32'(res_id), 32'(id));
            chk($sformatf("%s out c%0d", t, c), 32'(res_out), 32'(prod));
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with reset released: the next cycle is C0.
    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        hold      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        hold      = 1'b0;
        req_valid = 4'hF;
        req_a     = 32'h0403_0201;
        req_b     = 32'h0403_0201;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", 32'(req_ready), 32'h0);
        chk("rst mul_a", 32'(mul_a), 32'h0);
        chk("rst mul_b", 32'(mul_b), 32'h0);
        chk("rst res_valid", 32'(res_valid), 32'h0);
        chk("rst res_id", 32'(res_id), 32'h0);
        chk("rst res_out", 32'(res_out), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);

        // single op: 3*5 from requester 0, latency MUL_LAT+2
        do_reset();
        set_op(0, 8'd3, 8'd5);
        req_valid = 4'b0001;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            cyc_chk("t1", c, (c == 0) ? 4'b0001 : 4'b0000, c == 5, 0, 15);
            chk($sformatf("t1 busy c%0d", c), 32'(busy), 32'(c >= 1 && c <= 5));
            if (c == 1) begin
                chk("t1 mul_a", 32'(mul_a), 32'd3);
                chk("t1 mul_b", 32'(mul_b), 32'd5);
            end
            tick();
            req_valid = '0;
        end

        // all four from reset: grants 0..3 back to back, results 1,4,9,16
        do_reset();
        req_a = 32'h0403_0201;
        req_b = 32'h0403_0201;
        req_valid = 4'hF;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            cyc_chk("t2", c, (c < 4) ? 4'(1 << c) : 4'b0000,
                    c >= 5 && c <= 8, c - 5, (c - 4) * (c - 4));
            if (c >= 1 && c <= 4) chk($sformatf("t2 mul_a c%0d", c), 32'(mul_a), 32'(c));
            tick();
            if (c == 3) req_valid = '0;
        end

        // requester 2 streaming 255*255: one grant every MUL_LAT+2 cycles
        do_reset();
        set_op(2, 8'd255, 8'd255);
        req_valid = 4'b0100;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            cyc_chk("t3", c, (c % 5 == 0) ? 4'b0100 : 4'b0000,
                    c > 0 && c % 5 == 0, 2, 65025);
            tick();
        end

        // hold blocks grants for three cycles; in-flight op still returns
        do_reset();
        set_op(0, 8'd2, 8'd7);
        set_op(1, 8'd6, 8'd7);
        for (int c = 0; c <= 10; c++) begin
            hold      = (c >= 1 && c <= 3);
            req_valid = (c == 0) ? 4'b0011 : (c <= 4) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            cyc_chk("t4", c,
                    (c == 0) ? 4'b0001 : (c == 4) ? 4'b0010 : 4'b0000,
                    c == 5 || c == 9, (c == 5) ? 0 : 1, (c == 5) ? 14 : 42);
            tick();
        end

        // reset while ops for 0 and 1 are in flight: they must vanish
        do_reset();
        req_valid = 4'b0011;
        @(negedge clk);
        chk("t5 rdy c0", 32'(req_ready), 32'b0001);
        tick();
        @(negedge clk);
        chk("t5 rdy c1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'hF;
        reset_n   = 1'b0;
        @(negedge clk);
        chk("t5 mid rdy", 32'(req_ready), 32'h0);
        chk("t5 mid busy", 32'(busy), 32'h0);
        chk("t5 mid mul_a", 32'(mul_a), 32'h0);
        chk("t5 mid res_out", 32'(res_out), 32'h0);
        tick();
        tick();
        reset_n   = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t5 rv c%0d", c), 32'(res_valid), 32'h0);
            chk($sformatf("t5 busy c%0d", c), 32'(busy), 32'h0);
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk);
        chk("t5 first grant", 32'(req_ready), 32'b0001);
        tick();

        // last_grant=1 with 1 and 3 valid: 3 goes first, then 1
        do_reset();
        set_op(1, 8'd4, 8'd5);
        set_op(3, 8'd9, 8'd9);
        for (int c = 0; c <= 11; c++) begin
            req_valid = (c == 0) ? 4'b0010 : (c == 5) ? 4'b1010 :
                        (c == 6) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            cyc_chk("t6", c,
                    (c == 0) ? 4'b0010 : (c == 5) ? 4'b1000 :
                    (c == 6) ? 4'b0010 : 4'b0000,
                    c == 5 || c == 10 || c == 11,
                    (c == 10) ? 3 : 1, (c == 10) ? 81 : 20);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin scheduler sharing one pipelined 8x8 `multiplier` among NREQ requesters. Accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle to the multiplier. Tracks each in-flight operation's requester ID through a tag pipeline matched to the multiplier latency, then returns the tagged 16-bit product. Sits between the client blocks and the single `multiplier` instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- MUL_LAT, 3, cycles from `mul_a`/`mul_b` valid to matching `mul_out` valid (>=1)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- hold  in  1  when high, no new grants; in-flight ops complete normally
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_a  in  8*NREQ  operand A, requester i at bits [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- mul_a  out  8  operand A to multiplier, registered
- mul_b  out  8  operand B to multiplier, registered
- mul_out  in  16  product from multiplier
- res_valid  out  1  one-cycle result strobe, registered
- res_id  out  IDW  requester index of result, IDW = clog2(NREQ)
- res_out  out  16  product, registered
- busy  out  1  any operation in flight

## Operation
- Eligible[i] = req_valid[i] & ~outstanding[i] & ~hold.
- Round-robin: search starts at last_grant+1 mod NREQ; first eligible index wins. `req_ready` is combinational, high only for the winner.
- Transfer occurs when req_valid[i] & req_ready[i]. On transfer:
  - register req_a/req_b slice i into mul_a/mul_b;
  - set outstanding[i];
  - last_grant <= i;
  - push {1, i} into the tag pipeline.
- No transfer: mul_a/mul_b hold; push {0, x}.
- Each requester has at most one op outstanding, so results never reorder per requester.
- Tag pipeline depth MUL_LAT+1. At its output, when the valid bit is set:
  - res_valid <= 1, res_id <= tag id, res_out <= mul_out;
  - clear outstanding[id] on the same edge.
- busy = |outstanding.
- Arithmetic: unsigned 8x8 -> 16; the block passes `mul_out` through unmodified.
- No response backpressure: consumers must take res_* on the strobe cycle.

## Timing
- Transfer in cycle T:
  - mul_a/mul_b valid in T+1;
  - mul_out valid in T+1+MUL_LAT;
  - res_valid high in T+2+MUL_LAT.
- Total latency is MUL_LAT+2 cycles.
- Throughput: one issue per cycle across requesters; per requester, one op per MUL_LAT+2 cycles max.
- Requester i becomes eligible again in the cycle its res_valid is high, so the earliest re-grant is that same cycle.
- hold rising mid-stream: req_ready drops the same cycle (combinational); in-flight results still return.
- Reset values (asynchronous assert):
  - req_ready 0 while reset_n low;
  - mul_a, mul_b 0;
  - res_valid 0, res_id 0, res_out 0;
  - busy 0;
  - outstanding 0, tag pipeline valids 0;
  - last_grant NREQ-1, so requester 0 has first priority.
- Reset mid-operation discards all in-flight tags; no res_valid for them after release.
- Release of reset_n is synchronized externally to clk.

## Structure
- Shared package `mult_pkg`: OP_W=8, RES_W=16, default NREQ, MUL_LAT, and the IDW derivation function.
- Sub-module `rr_picker`: combinational round-robin one-hot select from eligible mask and last_grant, outputting grant one-hot and encoded index.
- Tag pipeline, outstanding mask and output registers live in `mult_arbiter`. The `multiplier` is instantiated at the parent level, not inside this block.

## Test plan
- After reset, req 0 only, a=3, b=5 in cycle T -> req_ready[0]=1 in T; res_valid in T+5 (MUL_LAT=3) with res_id=0, res_out=15; busy high T+1..T+5.
- All four requesters valid from reset, operands i+1 x i+1 -> grants 0,1,2,3 in consecutive cycles; results 1,4,9,16 with ids 0..3 in consecutive cycles.
- Req 2 held valid continuously with a=b=255 -> one grant per 5 cycles; every res_out=65025; req_ready[2] re-asserts in each res_valid cycle.
- hold=1 for 3 cycles while req 1 valid -> no req_ready during hold; grant in the first cycle hold=0; results already in flight still emerge on schedule.
- reset_n pulsed low 2 cycles after grants to req 0 and 1 -> no res_valid afterwards; all outputs 0; req 0 wins the next grant.
- Req 1 and req 3 valid, last_grant=1 -> req 3 granted first, then req 1.
